// File: rtl/mem_hier_pkg.sv
// Shared types for the cache miss-service engine: engine states and a
// parameter consistency helper.
package mem_hier_pkg;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  // Line address is {tag, index}; widths must agree.
  function automatic bit addr_w_ok(int addr_w, int tag_w, int index_w);
    return addr_w == tag_w + index_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after 'last',
// wrapping modulo NUM_PORTS.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     idx
);

  always_comb begin
    int   p;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    p     = 0;
    // k runs last+1 .. last+NUM_PORTS, so 'last' itself is checked last
    for (int k = 1; k <= NUM_PORTS; k++) begin
      p = (int'(last) + k) % NUM_PORTS;
      if (!found && req[p]) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/mem_miss_arbiter.sv
// Miss-service engine: serialises per-port cache misses onto one memory,
// writing back a dirty victim before fetching the fill line.
module mem_miss_arbiter
  import mem_hier_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int TAG_W     = 8,
  parameter int INDEX_W   = 6,
  parameter int ADDR_W    = 14,
  parameter int LINE_W    = 64,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]        req_dirty,
  input  logic [NUM_PORTS*TAG_W-1:0]  req_vtag,
  input  logic [NUM_PORTS*LINE_W-1:0] req_vdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [LINE_W-1:0]           fill_data,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_re,
  output logic                        mem_we,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_rdata,
  input  logic                        mem_rdy,
  output logic [CNT_W-1:0]            wb_count,
  output logic [CNT_W-1:0]            fill_count
);

  localparam int PID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  generate
    if (!addr_w_ok(ADDR_W, TAG_W, INDEX_W)) begin : g_bad_addr_w
      $error("mem_miss_arbiter: ADDR_W must equal TAG_W + INDEX_W");
    end
  endgenerate

  state_t                 state, next;
  logic [PID_W-1:0]       last, port, gidx;
  logic [NUM_PORTS-1:0]   grant;
  logic                   any;
  logic [ADDR_W-1:0]      addr_q, g_addr;
  logic                   g_dirty;
  logic [TAG_W-1:0]       g_vtag;
  logic [LINE_W-1:0]      g_vdata;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(PID_W)) u_rr (
    .req   (req),
    .last  (last),
    .grant (grant),
    .idx   (gidx)
  );

  assign any     = |grant;
  assign g_addr  = req_addr[gidx*ADDR_W +: ADDR_W];
  assign g_dirty = req_dirty[gidx];
  assign g_vtag  = req_vtag[gidx*TAG_W +: TAG_W];
  assign g_vdata = req_vdata[gidx*LINE_W +: LINE_W];

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (any) next = g_dirty ? WB : FILL;
      WB:      if (mem_rdy) next = FILL;
      FILL:    if (mem_rdy) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= PID_W'(NUM_PORTS - 1);
      port       <= '0;
      addr_q     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fill_data  <= '0;
      wb_count   <= '0;
      fill_count <= '0;
    end else begin
      state <= next;
      case (state)
        IDLE: if (any) begin
          last   <= gidx;
          port   <= gidx;
          addr_q <= g_addr;
          // mem_addr is set up a cycle early so it is stable with the strobe
          if (g_dirty) begin
            mem_addr  <= {g_vtag, g_addr[INDEX_W-1:0]};
            mem_wdata <= g_vdata;
          end else begin
            mem_addr  <= g_addr;
          end
        end
        WB: if (mem_rdy) begin
          mem_addr <= addr_q;
          wb_count <= wb_count + CNT_W'(~&wb_count);
        end
        FILL: if (mem_rdy) begin
          fill_data  <= mem_rdata;
          fill_count <= fill_count + CNT_W'(~&fill_count);
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state flop, so they drop with reset.
  assign busy   = (state != IDLE);
  assign mem_we = (state == WB);
  assign mem_re = (state == FILL);

  always_comb begin
    ack = '0;
    if (state == DONE) ack[port] = 1'b1;
  end

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Directed bench for mem_miss_arbiter with a latency-programmable memory
// model and a scoreboard of expected acks and fill lines.
module tb_mem_miss_arbiter;
  localparam int NP = 2, TW = 8, IW = 6, AW = 14, LW = 64, CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    req = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP-1:0]    req_dirty = '0;
  logic [NP*TW-1:0] req_vtag = '0;
  logic [NP*LW-1:0] req_vdata = '0;
  logic [NP-1:0]    ack;
  logic [LW-1:0]    fill_data, mem_wdata, mem_rdata;
  logic             busy, mem_re, mem_we;
  logic             mem_rdy = 1'b0;
  logic [AW-1:0]    mem_addr;
  logic [CW-1:0]    wb_count, fill_count;

  mem_miss_arbiter #(.NUM_PORTS(NP), .TAG_W(TW), .INDEX_W(IW), .ADDR_W(AW),
                     .LINE_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_dirty(req_dirty),
    .req_vtag(req_vtag), .req_vdata(req_vdata), .ack(ack), .fill_data(fill_data),
    .busy(busy), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .wb_count(wb_count), .fill_count(fill_count)
  );

  int vectors = 0, errs = 0;

  // ---------------- memory model ----------------
  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    return {16'hF1F1, 34'h0, a};
  endfunction

  logic          rd_override = 1'b0;
  logic [LW-1:0] rd_fixed = '0;
  assign mem_rdata = rd_override ? rd_fixed : mem_line(mem_addr);

  int            lat = 0, wcnt = 0;
  bit            we_seen = 0, both_seen = 0;
  logic [AW-1:0] wb_addr_q[$], rd_addr_q[$];
  logic [LW-1:0] wb_data_q[$];

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mem_rdy = 1'b0;
      wcnt    = 0;
    end else begin
      if (mem_we) we_seen = 1;
      if (mem_we && mem_re) both_seen = 1;
      if (mem_rdy) begin
        mem_rdy = 1'b0;
        wcnt    = 0;
      end
      if (mem_re || mem_we) begin
        if (wcnt >= lat) begin
          mem_rdy = 1'b1;
          if (mem_we) begin
            wb_addr_q.push_back(mem_addr);
            wb_data_q.push_back(mem_wdata);
          end else rd_addr_q.push_back(mem_addr);
        end else wcnt++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {int port; logic [LW-1:0] fill;} exp_t;
  exp_t exp_q[$];
  int   exp_wb = 0, exp_fill = 0;

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic [AW-1:0] a, input logic d,
                       input logic [TW-1:0] vt, input logic [LW-1:0] vd);
    exp_t e;
    req_addr[p*AW +: AW]  = a;
    req_dirty[p]          = d;
    req_vtag[p*TW +: TW]  = vt;
    req_vdata[p*LW +: LW] = vd;
    req[p]                = 1'b1;
    e.port = p;
    e.fill = rd_override ? rd_fixed : mem_line(a);
    exp_q.push_back(e);
    exp_fill = sat(exp_fill + 1);
    if (d) exp_wb = sat(exp_wb + 1);
  endtask

  task automatic wait_ack(output int p, output int n);
    p = -1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (|ack) begin
        for (int j = 0; j < NP; j++) if (ack[j]) p = j;
        break;
      end
    end
    check("ack_in_time", LW'(p >= 0), 1);
  endtask

  task automatic check_ack(input int p);
    exp_t e;
    if (p < 0) return;
    req[p] = 1'b0;
    check("sb_nonempty", LW'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ack_onehot", LW'(ack), LW'(1) << e.port);
      check("fill_data", fill_data, e.fill);
    end
  endtask

  task automatic pop_rd(input string tag, input logic [AW-1:0] a);
    check({tag, "_seen"}, LW'(rd_addr_q.size() > 0), 1);
    if (rd_addr_q.size() > 0) check(tag, LW'(rd_addr_q.pop_front()), LW'(a));
  endtask

  task automatic pop_wb(input logic [AW-1:0] a, input logic [LW-1:0] d);
    check("wb_seen", LW'(wb_addr_q.size() > 0), 1);
    if (wb_addr_q.size() > 0) begin
      check("wb_addr", LW'(wb_addr_q.pop_front()), LW'(a));
      check("wb_wdata", wb_data_q.pop_front(), d);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p, n, lowcnt, rdy_at, ack_at;
    bit bad, ack_any;
    logic [LW-1:0] held;

    #1 rst = 1'b1;
    #2;
    check("rst_ack", LW'(ack), 0);
    check("rst_busy", LW'(busy), 0);
    check("rst_mem_re", LW'(mem_re), 0);
    check("rst_mem_we", LW'(mem_we), 0);
    check("rst_mem_addr", LW'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_fill_data", fill_data, 0);
    check("rst_wb_count", LW'(wb_count), 0);
    check("rst_fill_count", LW'(fill_count), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // clean miss on port 0, memory answers after 2 cycles of mem_re
    lat = 2; rd_override = 1'b1; rd_fixed = 64'hDEADBEEF_CAFEF00D; we_seen = 0;
    drive(0, 14'h0123, 1'b0, '0, '0);
    wait_ack(p, n);
    check_ack(p);
    check("t1_we_never", LW'(we_seen), 0);
    pop_rd("t1_rd_addr", 14'h0123);
    check("t1_fill_count", LW'(fill_count), LW'(exp_fill));
    held = fill_data;
    tick();
    check("t1_ack_one_cycle", LW'(ack), 0);
    tick(); tick();
    check("t1_fill_hold", fill_data, 64'hDEADBEEF_CAFEF00D);
    rd_override = 1'b0;

    // dirty miss on port 1 at minimum latency
    lat = 0;
    drive(1, 14'h0105, 1'b1, 8'hA7, 64'h1111_2222_3333_4444);
    wait_ack(p, n);
    check("t2_latency", LW'(n + 1), 4);
    check_ack(p);
    pop_wb(14'h29C5, 64'h1111_2222_3333_4444);
    pop_rd("t2_rd_addr", 14'h0105);
    check("t2_wb_count", LW'(wb_count), LW'(exp_wb));
    check("t2_fill_count", LW'(fill_count), LW'(exp_fill));
    tick();

    // both ports request together and re-request straight after each ack
    drive(0, 14'h0040, 1'b0, '0, '0);
    drive(1, 14'h1FC3, 1'b0, '0, '0);
    for (int s = 0; s < 4; s++) begin
      wait_ack(p, n);
      if (s == 0) check("t3_clean_latency", LW'(n + 1), 3);
      check_ack(p);
      tick();
      if (s < 2 && p >= 0) drive(p, (p == 0) ? 14'h0040 : 14'h1FC3, 1'b0, '0, '0);
    end
    check("t3_no_overlap", LW'(both_seen), 0);
    rd_addr_q.delete();

    // memory stall of 50 cycles during FILL
    lat = 50;
    drive(1, 14'h0ABC, 1'b0, '0, '0);
    bad = 0; lowcnt = 0; rdy_at = -10; ack_at = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (|ack) begin
        ack_at = i;
        break;
      end
      if (!(mem_re === 1'b1 && busy === 1'b1)) bad = 1;
      if (mem_rdy) rdy_at = i; else lowcnt++;
    end
    check("t4_stall_re_busy", LW'(bad), 0);
    check("t4_stall_cycles", LW'(lowcnt), 50);
    check("t4_ack_after_rdy", LW'(ack_at - rdy_at), 1);
    check_ack(ack_at > 0 ? 1 : -1);
    pop_rd("t4_rd_addr", 14'h0ABC);
    tick();

    // asynchronous reset in the middle of a write-back
    lat = 10;
    drive(0, 14'h0222, 1'b1, 8'h33, 64'h5555_6666_7777_8888);
    void'(exp_q.pop_back());
    tick(); tick(); tick();
    check("t5_in_wb", LW'(mem_we), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_we", LW'(mem_we), 0);
    check("t5_rst_re", LW'(mem_re), 0);
    check("t5_rst_busy", LW'(busy), 0);
    check("t5_rst_ack", LW'(ack), 0);
    check("t5_rst_wb_count", LW'(wb_count), 0);
    check("t5_rst_fill_count", LW'(fill_count), 0);
    req = '0;
    exp_wb = 0; exp_fill = 0;
    wb_addr_q.delete(); wb_data_q.delete(); rd_addr_q.delete();
    #3 rst = 1'b0;
    ack_any = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (|ack) ack_any = 1;
    end
    check("t5_no_ack", LW'(ack_any), 0);
    lat = 1;
    drive(0, 14'h0777, 1'b0, '0, '0);
    wait_ack(p, n);
    check_ack(p);
    check("t5_fill_count", LW'(fill_count), 1);
    pop_rd("t5_rd_addr", 14'h0777);
    tick();

    // 17 dirty misses saturate both 4-bit counters
    lat = 0;
    for (int k = 0; k < 17; k++) begin
      drive(0, AW'(k * 3), 1'b1, TW'(k), LW'(k));
      wait_ack(p, n);
      check_ack(p);
      tick();
    end
    check("t6_wb_sat", LW'(wb_count), 15);
    check("t6_fill_sat", LW'(fill_count), 15);
    check("t6_sb_drained", LW'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
